// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial subtractor block.
//   SUB_WIDTH_DEFAULT : default operand/result width
//   sub_state_e       : controller states IDLE / RUN / DONE
package serial_sub_pkg;

  localparam int unsigned SUB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sub_state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell.
//   i_a, i_b : minuend / subtrahend bit
//   i_br     : borrow in
//   o_d      : difference bit  a ^ b ^ br
//   o_br     : borrow out      (~a & b) | (~(a ^ b) & br)
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_br,
  output logic o_d,
  output logic o_br
);

  always_comb begin
    o_d  = i_a ^ i_b ^ i_br;
    o_br = (~i_a & i_b) | (~(i_a ^ i_b) & i_br);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - borrow_in, one bit per cycle, LSB first.
//   i_clk, i_rst_n   : clock (rising edge), async active-low reset
//   i_start          : capture operands in IDLE and begin
//   i_bitA, i_bitB   : minuend, subtrahend (WIDTH bits)
//   i_borrow         : borrow in
//   i_ack            : consumer acknowledge of a DONE result
//   o_busy           : high in RUN and DONE
//   o_done           : result valid, held until acknowledged
//   o_diff/o_borrow  : difference and borrow out
//   o_zero           : high when o_diff == 0
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_bitA,
  input  logic [WIDTH-1:0] i_bitB,
  input  logic             i_borrow,
  input  logic             i_ack,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;

  logic             cell_d, cell_br;
  logic [WIDTH-1:0] res_shift;

  full_subtractor u_cell (
    .i_a  (a_q[0]),
    .i_b  (b_q[0]),
    .i_br (br_q),
    .o_d  (cell_d),
    .o_br (cell_br)
  );

  // Difference bits enter at the MSB so the first (LSB) bit lands at bit 0
  // after WIDTH shifts.
  assign res_shift = {cell_d, res_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          a_d     = i_bitA;
          b_d     = i_bitB;
          br_d    = i_borrow;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = cell_br;
        res_d = res_shift;
        cnt_d = cnt_q + CW'(1);
        // Final bit: publish the completed word directly from this cycle's
        // cell output so o_done rises on the WIDTH-th RUN edge.
        if (cnt_q == LAST_BIT) begin
          diff_d   = res_shift;
          borrow_d = cell_br;
          zero_d   = (res_shift == '0);
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_ack) begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_diff   = diff_q;
  assign o_borrow = borrow_q;
  assign o_zero   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       s8_start = 0, s8_ack = 0, s8_bin = 0;
  logic [7:0] s8_a = '0, s8_b = '0;
  logic       d8_busy, d8_done, d8_bor, d8_zero;
  logic [7:0] d8_diff;

  logic        s16_start = 0, s16_ack = 0, s16_bin = 0;
  logic [15:0] s16_a = '0, s16_b = '0;
  logic        d16_busy, d16_done, d16_bor, d16_zero;
  logic [15:0] d16_diff;

  int total = 0;
  int bad = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s8_start), .i_bitA(s8_a), .i_bitB(s8_b),
    .i_borrow(s8_bin), .i_ack(s8_ack), .o_busy(d8_busy), .o_done(d8_done),
    .o_diff(d8_diff), .o_borrow(d8_bor), .o_zero(d8_zero));

  serial_subtractor #(.WIDTH(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s16_start), .i_bitA(s16_a), .i_bitB(s16_b),
    .i_borrow(s16_bin), .i_ack(s16_ack), .o_busy(d16_busy), .o_done(d16_done),
    .o_diff(d16_diff), .o_borrow(d16_bor), .o_zero(d16_zero));

  // ---------------- behavioural reference model ----------------
  int          m_phase [2];   // 0 idle, 1 running, 2 result held
  int          m_left  [2];   // cycles remaining until result
  logic [31:0] m_A [2], m_B [2];
  logic        m_bin [2];
  logic        m_busy [2], m_done [2], m_bor [2], m_zero [2];
  logic [31:0] m_diff [2];

  function automatic int wid(input int k);
    return (k == 0) ? 8 : 16;
  endfunction

  function automatic logic in_start(input int k);
    return (k == 0) ? s8_start : s16_start;
  endfunction
  function automatic logic in_ack(input int k);
    return (k == 0) ? s8_ack : s16_ack;
  endfunction
  function automatic logic [31:0] in_a(input int k);
    return (k == 0) ? {24'b0, s8_a} : {16'b0, s16_a};
  endfunction
  function automatic logic [31:0] in_b(input int k);
    return (k == 0) ? {24'b0, s8_b} : {16'b0, s16_b};
  endfunction
  function automatic logic in_bin(input int k);
    return (k == 0) ? s8_bin : s16_bin;
  endfunction
  function automatic logic dut_done(input int k);
    return (k == 0) ? d8_done : d16_done;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_phase[k] = 0; m_left[k] = 0;
        m_busy[k] = 0; m_done[k] = 0; m_bor[k] = 0; m_zero[k] = 0; m_diff[k] = '0;
      end else begin
        case (m_phase[k])
          0: if (in_start(k)) begin
               m_A[k] = in_a(k); m_B[k] = in_b(k); m_bin[k] = in_bin(k);
               m_left[k] = wid(k); m_phase[k] = 1; m_busy[k] = 1;
             end
          1: begin
               m_left[k]--;
               if (m_left[k] == 0) begin
                 logic [63:0] r;
                 r = ({32'b0, m_A[k]} - {32'b0, m_B[k]} - {63'b0, m_bin[k]})
                     & ((64'd1 << (wid(k) + 1)) - 64'd1);
                 m_diff[k] = r[31:0] & ((32'd1 << wid(k)) - 32'd1);
                 m_bor[k]  = r[wid(k)];
                 m_zero[k] = (m_diff[k] == 0);
                 m_done[k] = 1;
                 m_phase[k] = 2;
               end
             end
          default: if (in_ack(k)) begin
               m_phase[k] = 0; m_done[k] = 0; m_busy[k] = 0;
             end
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [35:0] act, exp;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) act = {d8_busy, d8_done, d8_bor, d8_zero, 24'b0, d8_diff};
      else        act = {d16_busy, d16_done, d16_bor, d16_zero, 16'b0, d16_diff};
      exp = {m_busy[k], m_done[k], m_bor[k], m_zero[k], m_diff[k]};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL cycle_w%0d t=%0t got {busy,done,bor,zero,diff}=%h want %h",
                 wid(k), $time, act, exp);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input int k, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input logic bin);
    if (k == 0) begin s8_start = st; s8_a = a[7:0]; s8_b = b[7:0]; s8_bin = bin; end
    else begin s16_start = st; s16_a = a[15:0]; s16_b = b[15:0]; s16_bin = bin; end
  endtask

  task automatic set_start(input int k, input logic v);
    if (k == 0) s8_start = v; else s16_start = v;
  endtask

  task automatic set_ack(input int k, input logic v);
    if (k == 0) s8_ack = v; else s16_ack = v;
  endtask

  // Present start for one edge, wait (bounded) for done; edges counts the start edge.
  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic bin, output int edges);
    @(posedge clk); #1;
    drive(k, 1'b1, a, b, bin);
    @(posedge clk); edges = 1; #1;
    set_start(k, 1'b0);
    while (!dut_done(k) && edges < 60) begin
      @(posedge clk); edges++; #1;
    end
    if (!dut_done(k)) begin
      total++; bad++;
      $display("FAIL done_timeout_w%0d got done=0 want done=1", wid(k));
    end
  endtask

  task automatic ack_op(input int k, input int delay, input logic with_start);
    repeat (delay) @(posedge clk);
    #1; set_ack(k, 1'b1); set_start(k, with_start);
    @(posedge clk); #1; set_ack(k, 1'b0); set_start(k, 1'b0);
  endtask

  initial begin
    int e;
    #1 rst_n = 1'b0;
    #22 rst_n = 1'b1;
    #1;
    chk("reset_out", {d8_busy, d8_done, d8_bor, d8_zero, d8_diff}, 32'h0);

    run_op(0, 32'h5A, 32'h23, 1'b0, e);
    chk("lat_5a23", e, 9);
    chk("diff_5a23", {d8_bor, d8_zero, d8_diff}, {2'b00, 8'h37});
    ack_op(0, 0, 1'b0);

    run_op(0, 32'h00, 32'h01, 1'b0, e);
    chk("diff_0001", {d8_bor, d8_zero, d8_diff}, {2'b10, 8'hFF});
    ack_op(0, 1, 1'b0);

    run_op(0, 32'h10, 32'h0F, 1'b1, e);
    chk("diff_100f_b1", {d8_bor, d8_zero, d8_diff}, {2'b01, 8'h00});
    ack_op(0, 0, 1'b0);

    // start pulses during RUN and DONE must be ignored
    @(posedge clk); #1; drive(0, 1'b1, 32'h12, 32'h05, 1'b0);
    @(posedge clk); #1; set_start(0, 1'b0);
    @(posedge clk); #1; drive(0, 1'b1, 32'hFF, 32'h00, 1'b1);
    @(posedge clk); #1; set_start(0, 1'b0);
    e = 0;
    while (!d8_done && e < 40) begin @(posedge clk); e++; #1; end
    chk("run_start_ignored", {d8_done, d8_diff}, {1'b1, 8'h0D});
    drive(0, 1'b1, 32'h77, 32'h01, 1'b0);
    @(posedge clk); #1; set_start(0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("done_held", {d8_busy, d8_done, d8_bor, d8_zero, d8_diff}, {4'b1100, 8'h0D});
    drive(0, 1'b0, 32'h40, 32'h00, 1'b0);
    ack_op(0, 0, 1'b1);
    chk("ack_wins", {d8_busy, d8_done}, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    chk("start_dropped", {d8_busy, d8_done, d8_diff}, {2'b00, 8'h0D});

    // asynchronous reset during RUN cycle 4
    @(posedge clk); #1; drive(0, 1'b1, 32'h33, 32'h11, 1'b0);
    @(posedge clk); #1; set_start(0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst", {d8_busy, d8_done, d8_bor, d8_zero, d8_diff}, 32'h0);
    #1 rst_n = 1'b1;
    run_op(0, 32'hFF, 32'hFF, 1'b0, e);
    chk("lat_after_rst", e, 9);
    chk("diff_ffff", {d8_bor, d8_zero, d8_diff}, {2'b01, 8'h00});
    ack_op(0, 0, 1'b0);

    // randomized operations on both widths concurrently
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          int ed;
          run_op(0, $urandom, $urandom, 1'($urandom_range(0, 1)), ed);
          chk("lat_w8", ed, 9);
          ack_op(0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
      end
      begin
        for (int j = 0; j < 1000; j++) begin
          int ed;
          run_op(1, $urandom, $urandom, 1'($urandom_range(0, 1)), ed);
          chk("lat_w16", ed, 17);
          ack_op(1, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
      end
    join

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
